// File: rtl/mc_bus_arb2.sv
`timescale 1ns/1ps
// Two-port round-robin arbiter in front of the memory-cache core request/response port.
// Latency: request pulse in IDLE at t -> out_valid at t+1; ack/nak/rdata pass back combinationally.
// Backpressure: grant held on owner through NAK retries; non-owner requests latched until next IDLE.
module mc_bus_arb2 #(
    parameter  int ADDR_WIDTH = 24,
    localparam int BL         = ADDR_WIDTH - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [BL:0]   in0_addr_pre,
    input  logic          in0_valid,
    input  logic          in0_write,
    input  logic [31:0]   in0_wdata,
    input  logic [3:0]    in0_wmsk,
    output logic          in0_ack,
    output logic          in0_nak,
    input  logic [BL:0]   in1_addr_pre,
    input  logic          in1_valid,
    input  logic          in1_write,
    input  logic [31:0]   in1_wdata,
    input  logic [3:0]    in1_wmsk,
    output logic          in1_ack,
    output logic          in1_nak,
    output logic [31:0]   in_rdata,
    output logic [BL:0]   out_addr_pre,
    output logic          out_valid,
    output logic          out_write,
    output logic [31:0]   out_wdata,
    output logic [3:0]    out_wmsk,
    input  logic          out_ack,
    input  logic          out_nak,
    input  logic [31:0]   out_rdata
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;
    logic [1:0] pend_q,  pend_d;
    logic       issue_q, issue_d;

    logic [1:0] req;
    logic       sel_nxt;
    logic       busy;
    logic       grant;
    logic       own_valid;

    assign busy = (state_q == BUSY);

    // Request vector and round-robin pick; on a tie the port not granted last time wins.
    always_comb begin
        req     = pend_q | {in1_valid, in0_valid};
        sel_nxt = 1'b0;
        case (req)
            2'b10:   sel_nxt = 1'b1;
            2'b11:   sel_nxt = ~last_q;
            default: sel_nxt = 1'b0;
        endcase
    end

    // Next-state: grant in IDLE, release on ack, hold owner through naks; pend latches.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        issue_d = 1'b0;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant   = 1'b1;
                    state_d = BUSY;
                    owner_d = sel_nxt;
                    last_d  = sel_nxt;
                    issue_d = 1'b1;
                end
            end
            BUSY: begin
                if (out_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The owner's own valid while BUSY is a retry, not a new request, so it is not latched.
        // A grant in the same cycle consumes the request, so clear wins over set.
        pend_d[0] = (grant && (sel_nxt == 1'b0)) ? 1'b0 :
                    (pend_q[0] | (in0_valid & ~(busy & (owner_q == 1'b0))));
        pend_d[1] = (grant && (sel_nxt == 1'b1)) ? 1'b0 :
                    (pend_q[1] | (in1_valid & ~(busy & (owner_q == 1'b1))));
    end

    // Request/response muxing; naks forward the owner's retry pulse straight through.
    always_comb begin
        own_valid    = owner_q ? in1_valid : in0_valid;
        out_valid    = busy & (issue_q | own_valid);
        if (busy) begin
            out_addr_pre = owner_q ? in1_addr_pre : in0_addr_pre;
        end else begin
            out_addr_pre = sel_nxt ? in1_addr_pre : in0_addr_pre;
        end
        out_write    = owner_q ? in1_write : in0_write;
        out_wdata    = owner_q ? in1_wdata : in0_wdata;
        out_wmsk     = owner_q ? in1_wmsk  : in0_wmsk;
        in0_ack      = busy & out_ack & (owner_q == 1'b0);
        in1_ack      = busy & out_ack & (owner_q == 1'b1);
        in0_nak      = busy & out_nak & (owner_q == 1'b0);
        in1_nak      = busy & out_nak & (owner_q == 1'b1);
        in_rdata     = out_rdata;
    end

    // State registers; last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            pend_q  <= 2'b00;
            issue_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            issue_q <= issue_d;
        end
    end

endmodule

// File: tb/tb_mc_bus_arb2.sv
`timescale 1ns/1ps
// Directed, table-driven bench for mc_bus_arb2.
// One table row = one clock cycle of inputs plus the outputs expected in that cycle.
// Addresses and write payloads are fixed per port so each row only names the expected port.
module tb_mc_bus_arb2;

    localparam logic [23:0] A0 = 24'h000123;
    localparam logic [23:0] A1 = 24'h000456;
    localparam logic [31:0] W0 = 32'h11112222;
    localparam logic [31:0] W1 = 32'hA5A5A5A5;
    localparam logic [3:0]  M0 = 4'hF;
    localparam logic [3:0]  M1 = 4'h3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] in0_addr_pre, in1_addr_pre;
    logic        in0_valid, in1_valid, in0_write, in1_write;
    logic [31:0] in0_wdata, in1_wdata;
    logic [3:0]  in0_wmsk, in1_wmsk;
    logic        in0_ack, in0_nak, in1_ack, in1_nak;
    logic [31:0] in_rdata;
    logic [23:0] out_addr_pre;
    logic        out_valid, out_write;
    logic [31:0] out_wdata;
    logic [3:0]  out_wmsk;
    logic        out_ack, out_nak;
    logic [31:0] out_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_bus_arb2 #(.ADDR_WIDTH(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_addr_pre(in0_addr_pre), .in0_valid(in0_valid), .in0_write(in0_write),
        .in0_wdata(in0_wdata), .in0_wmsk(in0_wmsk), .in0_ack(in0_ack), .in0_nak(in0_nak),
        .in1_addr_pre(in1_addr_pre), .in1_valid(in1_valid), .in1_write(in1_write),
        .in1_wdata(in1_wdata), .in1_wmsk(in1_wmsk), .in1_ack(in1_ack), .in1_nak(in1_nak),
        .in_rdata(in_rdata), .out_addr_pre(out_addr_pre), .out_valid(out_valid),
        .out_write(out_write), .out_wdata(out_wdata), .out_wmsk(out_wmsk),
        .out_ack(out_ack), .out_nak(out_nak), .out_rdata(out_rdata)
    );

    typedef struct {
        bit          v0, v1, ack, nak;
        logic [31:0] rd;
        bit          ov;    // expected out_valid
        bit          ca;    // check address (and payload when ov)
        bit          p;     // port whose address/payload is expected
        bit          a0, a1, n0, n1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t r(bit v0, bit v1, bit ack, bit nak, logic [31:0] rd,
                               bit ov, bit ca, bit p, bit a0, bit a1, bit n0, bit n1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.ack = ack; v.nak = nak; v.rd = rd;
        v.ov = ov; v.ca = ca; v.p = p;
        v.a0 = a0; v.a1 = a1; v.n0 = n0; v.n1 = n1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one row just after the rising edge, compare mid-cycle.
    task automatic run_row(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        in0_valid = v.v0; in1_valid = v.v1;
        out_ack   = v.ack; out_nak = v.nak; out_rdata = v.rd;
        #4;
        chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, v.ov});
        chk({tag, " in0_ack"},   {31'b0, in0_ack},   {31'b0, v.a0});
        chk({tag, " in1_ack"},   {31'b0, in1_ack},   {31'b0, v.a1});
        chk({tag, " in0_nak"},   {31'b0, in0_nak},   {31'b0, v.n0});
        chk({tag, " in1_nak"},   {31'b0, in1_nak},   {31'b0, v.n1});
        chk({tag, " in_rdata"},  in_rdata, v.rd);
        if (v.ca) begin
            chk({tag, " out_addr_pre"}, {8'b0, out_addr_pre}, {8'b0, (v.p ? A1 : A0)});
            if (v.ov) begin
                chk({tag, " out_write"}, {31'b0, out_write}, {31'b0, v.p});
                chk({tag, " out_wdata"}, out_wdata, v.p ? W1 : W0);
                chk({tag, " out_wmsk"},  {28'b0, out_wmsk}, {28'b0, (v.p ? M1 : M0)});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in0_addr_pre = A0; in1_addr_pre = A1;
        in0_write = 1'b0;  in1_write = 1'b1;
        in0_wdata = W0;    in1_wdata = W1;
        in0_wmsk  = M0;    in1_wmsk  = M1;
        in0_valid = 1'b0;  in1_valid = 1'b0;
        out_ack = 1'b1; out_nak = 1'b1; out_rdata = 32'h0;

        //       v0 v1 ak nk rdata         ov ca p  a0 a1 n0 n1
        // tie straight after reset: port 0 first, port 1 at ack+2
        tbl.push_back(r(1, 1, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 1, 0, 32'h0BADF00D, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 1, 0, 32'h12345678, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0));
        // second tie after port 1 served: port 0 again
        tbl.push_back(r(1, 1, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 1, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0));
        // port 1 owns: nak + retry, port 0 pulses mid-retry and waits
        tbl.push_back(r(0, 1, 0, 1, 32'h0,        1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(r(1, 0, 0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(0, 1, 0, 1, 32'h0,        1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(r(0, 0, 1, 0, 32'hCAFEF00D, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 1, 0, 0, 0));
        // spurious responses in IDLE
        tbl.push_back(r(0, 0, 1, 0, 32'h55AA55AA, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0));
        // single port 0 read, ack at t+4
        tbl.push_back(r(1, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(r(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0));

        // Outputs under reset, with responses driven
        in0_valid = 1'b1; in1_valid = 1'b1;
        #12;
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst in0_ack",   {31'b0, in0_ack},   32'd0);
        chk("rst in1_ack",   {31'b0, in1_ack},   32'd0);
        chk("rst in0_nak",   {31'b0, in0_nak},   32'd0);
        chk("rst in1_nak",   {31'b0, in1_nak},   32'd0);
        @(posedge clk);
        #1;
        in0_valid = 1'b0; in1_valid = 1'b0; out_ack = 1'b0; out_nak = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i], $sformatf("row%0d", i));
        end

        // Reset mid-transaction: port 1 owns, port 0 pending
        run_row(r(0, 1, 0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0), "mr0");
        run_row(r(1, 0, 0, 0, 32'h0, 1, 1, 1, 0, 0, 0, 0), "mr1");
        @(posedge clk);
        #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        #2;
        rst_n = 1'b0; out_ack = 1'b1;
        #1;
        chk("mr out_valid", {31'b0, out_valid}, 32'd0);
        chk("mr in1_ack",   {31'b0, in1_ack},   32'd0);
        chk("mr in0_ack",   {31'b0, in0_ack},   32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; out_ack = 1'b0;
        // dropped pend: nothing issues without a fresh pulse
        run_row(r(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), "pr0");
        run_row(r(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), "pr1");
        run_row(r(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), "pr2");
        // first tie after reset goes to port 0
        run_row(r(1, 1, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0), "pt0");
        run_row(r(0, 0, 0, 0, 32'h0, 1, 1, 0, 0, 0, 0, 0), "pt1");
        run_row(r(0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 0, 0, 0), "pt2");
        run_row(r(0, 0, 0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0), "pt3");
        run_row(r(0, 0, 0, 0, 32'h0, 1, 1, 1, 0, 0, 0, 0), "pt4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
